// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: one control word plus one datapath word per beat,
// with a one-beat skid buffer, per-beat bubble insertion, flush and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 111,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              kill,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat moves across a port on a rising edge where valid and ready are
  // both high. Upstream must hold in_valid/in_ctrl/in_data stable until it is accepted.
  // in_ready is decoded from registered state only, so it never depends on out_ready.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic              accept;
  logic              pop;
  logic [CTRL_W-1:0] in_ctrl_eff;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // A killed beat keeps its data but loses all control effects.
  assign in_ctrl_eff = kill ? '0 : in_ctrl;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Data registers keep their contents; only the control words are scrubbed.
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl_eff;
            main_data_d = in_data;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            skid_ctrl_d = in_ctrl_eff;
            skid_data_d = in_data;
            state_d     = ST_FULL;
          end else if (accept && pop) begin
            main_ctrl_d = in_ctrl_eff;
            main_data_d = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (accept && kill && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_ctrl   = out_valid ? main_ctrl_q : '0;
  assign out_data   = main_data_q;
  assign bubble_cnt = bubble_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one task per scenario, inline checks, one summary line.
module tb_pipe_stage_reg;

  localparam int CW = 11;
  localparam int DW = 111;
  localparam int NW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid, in_ready, kill, flush, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] bubble_cnt;
  logic [1:0]    dbg_state;

  logic          s_in_valid, s_in_ready, s_kill, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_bubble_cnt;
  logic [1:0]    s_dbg_state;

  int total;
  int bad;
  logic [NW-1:0] exp_bubble;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .kill(kill), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .bubble_cnt(bubble_cnt), .dbg_state(dbg_state)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(11'h123), .in_data(111'h77),
    .kill(s_kill), .flush(1'b0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .bubble_cnt(s_bubble_cnt), .dbg_state(s_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (out_ctrl !== 11'h0) begin bad++; $display("FAIL reset_out_ctrl got=%0h exp=0", out_ctrl); end
    total++; if (out_data !== 111'h0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    total++; if (bubble_cnt !== 16'h0) begin bad++; $display("FAIL reset_bubble got=%0d exp=0", bubble_cnt); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      offer(11'h7FF, DW'(k));
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%0b exp=1", k, out_valid); end
      total++; if (out_data !== DW'(k)) begin bad++; $display("FAIL stream_data k=%0d got=%0h exp=%0h", k, out_data, k); end
      total++; if (out_ctrl !== 11'h7FF) begin bad++; $display("FAIL stream_ctrl k=%0d got=%0h exp=7ff", k, out_ctrl); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready k=%0d got=%0b exp=1", k, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    offer(11'h001, 111'hA1);
    tick();
    total++; if (out_data !== 111'hA1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_a data=%0h ready=%0b exp=a1/1", out_data, in_ready); end
    offer(11'h002, 111'hB2);
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
    total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL bp_full_state got=%0d exp=2", dbg_state); end
    offer(11'h003, 111'hC3);
    tick();
    total++; if (out_data !== 111'hA1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold data=%0h ready=%0b exp=a1/0", out_data, in_ready); end
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 111'hB2 || out_ctrl !== 11'h002) begin bad++; $display("FAIL bp_b data=%0h ctrl=%0h exp=b2/2", out_data, out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_recover_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 111'hC3 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_c data=%0h valid=%0b exp=c3/1", out_data, out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_accept_pop_one();
    out_ready = 1'b0;
    offer(11'h011, 111'h111);
    tick();
    out_ready = 1'b1;
    offer(11'h022, 111'h222);
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 111'h222 || out_ctrl !== 11'h022) begin bad++; $display("FAIL ap_data data=%0h ctrl=%0h exp=222/22", out_data, out_ctrl); end
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL ap_state got=%0d exp=1", dbg_state); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ap_no_skid valid=%0b exp=0", out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    offer(11'h5A5, 111'hDEAD);
    kill = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_bubble = 16'd1;
    total++; if (out_ctrl !== 11'h0 || out_valid !== 1'b1) begin bad++; $display("FAIL bubble_ctrl ctrl=%0h valid=%0b exp=0/1", out_ctrl, out_valid); end
    total++; if (out_data !== 111'hDEAD) begin bad++; $display("FAIL bubble_data got=%0h exp=dead", out_data); end
    total++; if (bubble_cnt !== exp_bubble) begin bad++; $display("FAIL bubble_cnt got=%0d exp=%0d", bubble_cnt, exp_bubble); end
    out_ready = 1'b1;
    tick();
    kill = 1'b0;
    total++; if (bubble_cnt !== exp_bubble) begin bad++; $display("FAIL bubble_no_accept got=%0d exp=%0d", bubble_cnt, exp_bubble); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat;
    s_in_valid = 1'b1;
    s_kill     = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_sat = (i > 3) ? 2'd3 : 2'(i);
      total++; if (s_bubble_cnt !== exp_sat) begin bad++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, s_bubble_cnt, exp_sat); end
    end
    s_in_valid = 1'b0;
    s_kill     = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(11'h00F, 111'h0AA);
    tick();
    offer(11'h0F0, 111'h0BB);
    tick();
    total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL flush_pre_full got=%0d exp=2", dbg_state); end
    offer(11'h333, 111'h333);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_state valid=%0b ready=%0b exp=0/1", out_valid, in_ready); end
    total++; if (out_ctrl !== 11'h0) begin bad++; $display("FAIL flush_ctrl got=%0h exp=0", out_ctrl); end
    total++; if (bubble_cnt !== exp_bubble) begin bad++; $display("FAIL flush_bubble got=%0d exp=%0d", bubble_cnt, exp_bubble); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%0b exp=0", out_valid); end
    flush = 1'b1;
    offer(11'h444, 111'h444);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_hold i=%0d got=%0b exp=0", i, out_valid); end
    end
    flush = 1'b0;
    offer(11'h055, 111'h555);
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 111'h555 || out_ctrl !== 11'h055) begin bad++; $display("FAIL flush_resume data=%0h ctrl=%0h exp=555/55", out_data, out_ctrl); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    offer(11'h101, 111'h901);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    offer(11'h102, 111'h902);
    tick();
    in_valid = 1'b0;
    total++; if (dbg_state !== 2'd2 || bubble_cnt === 16'h0) begin bad++; $display("FAIL rmid_pre state=%0d bubble=%0d exp=2/nonzero", dbg_state, bubble_cnt); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rmid_flags valid=%0b ready=%0b exp=0/1", out_valid, in_ready); end
    total++; if (out_ctrl !== 11'h0 || out_data !== 111'h0) begin bad++; $display("FAIL rmid_words ctrl=%0h data=%0h exp=0/0", out_ctrl, out_data); end
    total++; if (bubble_cnt !== 16'h0 || dbg_state !== 2'd0) begin bad++; $display("FAIL rmid_cnt bubble=%0d state=%0d exp=0/0", bubble_cnt, dbg_state); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    exp_bubble = '0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_ctrl    = '0;
    in_data    = '0;
    kill       = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    s_in_valid = 1'b0;
    s_kill     = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_accept_pop_one();
    test_bubble();
    test_saturation();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
